// File: rtl/stream_demux1ton.sv
// stream_demux1ton: packet-aware 1-to-N stream demultiplexer.
// One registered output slot with a shared data/last bus and one-hot m_valid.
// The select is captured on a packet's first beat and held until s_last.
// Packets whose select is out of range are consumed and dropped.
// Optional feature macro: DEMUX_DROP_CNT_EN adds a saturating 16-bit drop counter port.
module stream_demux1ton #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_OUT = 2,
  parameter int unsigned SEL_W   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  s_data,
  input  logic [SEL_W-1:0]   s_sel,
  input  logic               s_last,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_last,
  output logic [NUM_OUT-1:0] m_valid,
  input  logic [NUM_OUT-1:0] m_ready,
  output logic               busy,
  output logic               drop_pulse
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]        drop_cnt
`endif
);

  localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W+1)'(NUM_OUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SEL_W-1:0]   held_sel;
  logic [SEL_W-1:0]   route_sel;
  logic [NUM_OUT-1:0] sel_onehot;
  logic               slot_free;
  logic               slot_hs;
  logic               sel_ok;
  logic               accept;
  logic               load;
  logic               drop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: packet boundaries are tracked only on accepted beats
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !s_last) begin
          state_next = sel_ok ? ROUTE : DROP;
        end
      end
      ROUTE, DROP: begin
        if (accept && s_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake and slot control; only the first beat's select is honoured
  always_comb begin
    slot_hs   = |(m_valid & m_ready);
    slot_free = !(|m_valid) || slot_hs;
    sel_ok    = {1'b0, s_sel} < NUM_OUT_L;
    s_ready   = (state == DROP) ? 1'b1 : slot_free;
    accept    = s_valid && s_ready;
    route_sel = (state == IDLE) ? s_sel : held_sel;
    load      = accept && ((state == ROUTE) || ((state == IDLE) && sel_ok));
    drop      = accept && (state == IDLE) && !sel_ok;
    for (int i = 0; i < int'(NUM_OUT); i++) begin
      sel_onehot[i] = (route_sel == SEL_W'(i));
    end
  end

  // Output slot, held select and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= '0;
      m_data     <= '0;
      m_last     <= 1'b0;
      held_sel   <= '0;
      busy       <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      busy       <= (state_next != IDLE);
      drop_pulse <= drop;
      if (accept && (state == IDLE)) begin
        held_sel <= s_sel;
      end
      if (load) begin
        m_valid <= sel_onehot;
        m_data  <= s_data;
        m_last  <= s_last;
      end else if (slot_hs) begin
        m_valid <= '0;
      end
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  // Saturating count of dropped packets
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= 16'd0;
    end else if (drop_pulse && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux1ton.sv
// tb_stream_demux1ton: directed bench for stream_demux1ton.
// DUT a: NUM_OUT=2 (all selects valid). DUT b: NUM_OUT=3 (select 3 drops).
module tb_stream_demux1ton;

  logic       clk;
  logic       rst_n;

  logic [7:0] a_s_data;
  logic       a_s_sel;
  logic       a_s_last;
  logic       a_s_valid;
  logic       a_s_ready;
  logic [7:0] a_m_data;
  logic       a_m_last;
  logic [1:0] a_m_valid;
  logic [1:0] a_m_ready;
  logic       a_busy;
  logic       a_drop_pulse;

  logic [7:0] b_s_data;
  logic [1:0] b_s_sel;
  logic       b_s_last;
  logic       b_s_valid;
  logic       b_s_ready;
  logic [7:0] b_m_data;
  logic       b_m_last;
  logic [2:0] b_m_valid;
  logic [2:0] b_m_ready;
  logic       b_busy;
  logic       b_drop_pulse;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] a_drop_cnt;
  logic [15:0] b_drop_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  stream_demux1ton #(.DATA_W(8), .NUM_OUT(2), .SEL_W(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .s_data(a_s_data), .s_sel(a_s_sel), .s_last(a_s_last),
    .s_valid(a_s_valid), .s_ready(a_s_ready),
    .m_data(a_m_data), .m_last(a_m_last), .m_valid(a_m_valid),
    .m_ready(a_m_ready), .busy(a_busy), .drop_pulse(a_drop_pulse)
`ifdef DEMUX_DROP_CNT_EN
    , .drop_cnt(a_drop_cnt)
`endif
  );

  stream_demux1ton #(.DATA_W(8), .NUM_OUT(3), .SEL_W(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .s_data(b_s_data), .s_sel(b_s_sel), .s_last(b_s_last),
    .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_data(b_m_data), .m_last(b_m_last), .m_valid(b_m_valid),
    .m_ready(b_m_ready), .busy(b_busy), .drop_pulse(b_drop_pulse)
`ifdef DEMUX_DROP_CNT_EN
    , .drop_cnt(b_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [7:0] d, input logic sel, input logic last, input logic vld);
    a_s_data  = d;
    a_s_sel   = sel;
    a_s_last  = last;
    a_s_valid = vld;
    #1;
  endtask

  task automatic drive_b(input logic [7:0] d, input logic [1:0] sel, input logic last, input logic vld);
    b_s_data  = d;
    b_s_sel   = sel;
    b_s_last  = last;
    b_s_valid = vld;
    #1;
  endtask

  // Checks of DUT a's registered slot
  task automatic chk_a(input string tag, input logic [1:0] v, input logic [7:0] d, input logic l);
    chk({tag, ".m_valid"}, 32'(a_m_valid), 32'(v));
    if (v != 2'b00) begin
      chk({tag, ".m_data"}, 32'(a_m_data), 32'(d));
      chk({tag, ".m_last"}, 32'(a_m_last), 32'(l));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_m_ready = 2'b00;
    b_m_ready = 3'b000;
    drive_a(8'h00, 1'b0, 1'b0, 1'b0);
    drive_b(8'h00, 2'd0, 1'b0, 1'b0);
    repeat (3) tick();

    // Reset values
    chk("rst.a_m_valid", 32'(a_m_valid), 32'h0);
    chk("rst.a_m_data", 32'(a_m_data), 32'h0);
    chk("rst.a_m_last", 32'(a_m_last), 32'h0);
    chk("rst.a_busy", 32'(a_busy), 32'h0);
    chk("rst.a_drop", 32'(a_drop_pulse), 32'h0);
    chk("rst.b_m_valid", 32'(b_m_valid), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
    chk("rst.b_drop_cnt", 32'(b_drop_cnt), 32'h0);
`endif
    rst_n = 1'b1;
    tick();

    // Basic 3-beat packet to output 1
    a_m_ready = 2'b10;
    drive_a(8'hA1, 1'b1, 1'b0, 1'b1);
    chk("pkt.s_ready0", 32'(a_s_ready), 32'h1);
    tick();
    chk_a("pkt.b1", 2'b10, 8'hA1, 1'b0);
    chk("pkt.busy1", 32'(a_busy), 32'h1);
    drive_a(8'hA2, 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("pkt.b2", 2'b10, 8'hA2, 1'b0);
    drive_a(8'hA3, 1'b1, 1'b1, 1'b1);
    tick();
    chk_a("pkt.b3", 2'b10, 8'hA3, 1'b1);
    chk("pkt.busy3", 32'(a_busy), 32'h0);
    drive_a(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_a("pkt.clear", 2'b00, 8'h00, 1'b0);

    // Backpressure on output 0
    a_m_ready = 2'b00;
    drive_a(8'hB1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_a("bp.b1", 2'b01, 8'hB1, 1'b0);
    drive_a(8'hB2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp.s_ready", 32'(a_s_ready), 32'h0);
      tick();
      chk_a("bp.hold", 2'b01, 8'hB1, 1'b0);
    end
    a_m_ready = 2'b01;
    #1;
    chk("bp.s_ready_rel", 32'(a_s_ready), 32'h1);
    tick();
    chk_a("bp.b2", 2'b01, 8'hB2, 1'b0);
    drive_a(8'hB3, 1'b0, 1'b1, 1'b1);
    tick();
    chk_a("bp.b3", 2'b01, 8'hB3, 1'b1);
    drive_a(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_a("bp.clear", 2'b00, 8'h00, 1'b0);

    // Back-to-back packets to different outputs
    a_m_ready = 2'b11;
    drive_a(8'hC1, 1'b0, 1'b1, 1'b1);
    tick();
    chk_a("b2b.c1", 2'b01, 8'hC1, 1'b1);
    chk("b2b.busy_c1", 32'(a_busy), 32'h0);
    drive_a(8'hD1, 1'b1, 1'b0, 1'b1);
    chk("b2b.s_ready_d1", 32'(a_s_ready), 32'h1);
    tick();
    chk_a("b2b.d1", 2'b10, 8'hD1, 1'b0);
    drive_a(8'hD2, 1'b1, 1'b1, 1'b1);
    tick();
    chk_a("b2b.d2", 2'b10, 8'hD2, 1'b1);

    // Select toggled on later beats is ignored
    drive_a(8'hE1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("sel.e1", 2'b10, 8'hE1, 1'b0);
    drive_a(8'hE2, 1'b0, 1'b0, 1'b1);
    tick();
    chk_a("sel.e2", 2'b10, 8'hE2, 1'b0);
    drive_a(8'hE3, 1'b0, 1'b1, 1'b1);
    tick();
    chk_a("sel.e3", 2'b10, 8'hE3, 1'b1);
    drive_a(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_a("sel.clear", 2'b00, 8'h00, 1'b0);

    // Reset in the middle of a packet with the slot full
    a_m_ready = 2'b00;
    drive_a(8'hF1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_a("mrst.f1", 2'b01, 8'hF1, 1'b0);
    chk("mrst.busy_pre", 32'(a_busy), 32'h1);
    drive_a(8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst.m_valid", 32'(a_m_valid), 32'h0);
    chk("mrst.busy", 32'(a_busy), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    drive_a(8'h61, 1'b1, 1'b1, 1'b1);
    chk("mrst.s_ready", 32'(a_s_ready), 32'h1);
    tick();
    chk_a("mrst.g1", 2'b10, 8'h61, 1'b1);
    chk("mrst.busy_g1", 32'(a_busy), 32'h0);
    a_m_ready = 2'b10;
    drive_a(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_a("mrst.clear", 2'b00, 8'h00, 1'b0);

    // NUM_OUT=3: 4-beat packet with select 3 is dropped
    b_m_ready = 3'b111;
    drive_b(8'h11, 2'd3, 1'b0, 1'b1);
    chk("drop.s_ready1", 32'(b_s_ready), 32'h1);
    tick();
    chk("drop.pulse1", 32'(b_drop_pulse), 32'h1);
    chk("drop.m_valid1", 32'(b_m_valid), 32'h0);
    chk("drop.busy1", 32'(b_busy), 32'h1);
    b_m_ready = 3'b000;
    drive_b(8'h12, 2'd0, 1'b0, 1'b1);
    chk("drop.s_ready2", 32'(b_s_ready), 32'h1);
    tick();
    chk("drop.pulse2", 32'(b_drop_pulse), 32'h0);
    chk("drop.m_valid2", 32'(b_m_valid), 32'h0);
    drive_b(8'h13, 2'd1, 1'b0, 1'b1);
    chk("drop.s_ready3", 32'(b_s_ready), 32'h1);
    tick();
    drive_b(8'h14, 2'd2, 1'b1, 1'b1);
    chk("drop.s_ready4", 32'(b_s_ready), 32'h1);
    tick();
    chk("drop.pulse4", 32'(b_drop_pulse), 32'h0);
    chk("drop.m_valid4", 32'(b_m_valid), 32'h0);
    chk("drop.busy4", 32'(b_busy), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
    chk("drop.cnt1", 32'(b_drop_cnt), 32'h1);
`endif

    // NUM_OUT=3: select 2 is routed, then a single-beat dropped packet
    b_m_ready = 3'b100;
    drive_b(8'h21, 2'd2, 1'b1, 1'b1);
    tick();
    chk("b.route2.m_valid", 32'(b_m_valid), 32'h4);
    chk("b.route2.m_data", 32'(b_m_data), 32'h21);
    drive_b(8'h31, 2'd3, 1'b1, 1'b1);
    tick();
    chk("b.drop1.pulse", 32'(b_drop_pulse), 32'h1);
    chk("b.drop1.m_valid", 32'(b_m_valid), 32'h0);
    chk("b.drop1.busy", 32'(b_busy), 32'h0);
    drive_b(8'h00, 2'd0, 1'b0, 1'b0);
    tick();
    chk("b.drop1.pulse_end", 32'(b_drop_pulse), 32'h0);
`ifdef DEMUX_DROP_CNT_EN
    chk("b.drop1.cnt", 32'(b_drop_cnt), 32'h2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
